// File: rtl/ram64_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a 64x16 single-port RAM.
// Define RAM64_ARB_FIXED_PRIO_EN to make port A always win contention.
module ram64_arbiter #(
    parameter int ADDR_W    = 6,
    parameter int DATA_W    = 16,
    parameter bit INIT_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_done,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_done,
    output logic [DATA_W-1:0] b_rdata,
    output logic              mem_e,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_w,
    output logic              mem_r,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t state;
    logic   win_b;   // 1 = port B owns the current access
    logic   pick_b;

`ifdef RAM64_ARB_FIXED_PRIO_EN
    assign pick_b = b_req && !a_req;
`else
    logic prio;      // 1 = B wins the next contention
    assign pick_b = b_req && (!a_req || prio);
`endif

    // mem_addr/mem_din double as the latched command; they only matter while mem_e is high.
    // NOTE: all state and outputs use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
`ifndef RAM64_ARB_FIXED_PRIO_EN
            prio     <= INIT_PRIO;
`endif
            win_b    <= 1'b0;
            a_gnt    <= 1'b0;
            b_gnt    <= 1'b0;
            a_done   <= 1'b0;
            b_done   <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
            mem_e    <= 1'b0;
            mem_w    <= 1'b0;
            mem_r    <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (a_req || b_req) begin
                        win_b    <= pick_b;
                        mem_addr <= pick_b ? b_addr  : a_addr;
                        mem_din  <= pick_b ? b_wdata : a_wdata;
                        mem_w    <= pick_b ? b_we    : a_we;
                        mem_r    <= pick_b ? !b_we   : !a_we;
                        mem_e    <= 1'b1;
                        a_gnt    <= !pick_b;
                        b_gnt    <= pick_b;
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    // mem_r is only high for a read, so an idle RAM's x output is never captured
                    if (mem_r) begin
                        if (win_b) b_rdata <= mem_dout;
                        else       a_rdata <= mem_dout;
                    end
                    mem_e  <= 1'b0;
                    mem_w  <= 1'b0;
                    mem_r  <= 1'b0;
                    a_gnt  <= 1'b0;
                    b_gnt  <= 1'b0;
                    a_done <= !win_b;
                    b_done <= win_b;
                    state  <= RESP;
                end
                RESP: begin
                    a_done <= 1'b0;
                    b_done <= 1'b0;
`ifndef RAM64_ARB_FIXED_PRIO_EN
                    prio   <= !win_b;
`endif
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram64_arbiter.sv
// Self-checking bench for ram64_arbiter: a behavioural RAM, a transaction-level
// reference model (timestamps + arrays), directed steps and a randomized phase.
module tb_ram64_arbiter;
    localparam int AW = 6;
    localparam int DW = 16;
    localparam bit INIT_PRIO = 1'b0;

    logic clk = 1'b0;
    logic rst_n;
    logic a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic a_gnt, a_done, b_gnt, b_done;
    logic [DW-1:0] a_rdata, b_rdata;
    logic mem_e, mem_w, mem_r;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din, mem_dout;

    ram64_arbiter #(.ADDR_W(AW), .DATA_W(DW), .INIT_PRIO(INIT_PRIO)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_done(a_done), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_done(b_done), .b_rdata(b_rdata),
        .mem_e(mem_e), .mem_addr(mem_addr), .mem_w(mem_w), .mem_r(mem_r),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    // Behavioural RAM64: combinational read, rising-edge write.
    logic [DW-1:0] ram [64];
    assign mem_dout = ram[mem_addr];
    always @(posedge clk) if (mem_e && mem_w) ram[mem_addr] <= mem_din;

    // Reference model: an access granted at edge g shows gnt in period g,
    // done in period g+1, takes effect at edge g+1, next arbitration at edge g+3.
    int cyc = 0;
    int g;
    int free_edge;
    bit m_prio;
    bit m_win;
    bit m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] ref_mem [64];
    logic [DW-1:0] exp_rdata [2];

    int vectors = 0;
    int miscompares = 0;

    function automatic logic [DW-1:0] init_val(int i);
        return 16'(i * 257) ^ 16'h5A5A;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        g         = -100;
        free_edge = 0;
        m_prio    = INIT_PRIO;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
    endtask

    task automatic model_edge();
        cyc++;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (cyc == g + 1) begin
            if (m_we) ref_mem[m_addr] = m_wdata;
            else      exp_rdata[m_win] = ref_mem[m_addr];
        end
        if (cyc >= free_edge && (a_req || b_req)) begin
`ifdef RAM64_ARB_FIXED_PRIO_EN
            m_win = !a_req;
`else
            m_win  = (a_req && b_req) ? m_prio : b_req;
            m_prio = !m_win;
`endif
            m_we      = m_win ? b_we    : a_we;
            m_addr    = m_win ? b_addr  : a_addr;
            m_wdata   = m_win ? b_wdata : a_wdata;
            g         = cyc;
            free_edge = cyc + 3;
        end
    endtask

    task automatic compare_all();
        bit acc;
        acc = (cyc == g);
        check("a_gnt",  a_gnt,  acc && !m_win);
        check("b_gnt",  b_gnt,  acc && m_win);
        check("mem_e",  mem_e,  acc);
        check("mem_w",  mem_w,  acc && m_we);
        check("mem_r",  mem_r,  acc && !m_we);
        if (acc) check("mem_addr", mem_addr, m_addr);
        if (acc && m_we) check("mem_din", mem_din, m_wdata);
        check("a_done", a_done, (cyc == g + 1) && !m_win);
        check("b_done", b_done, (cyc == g + 1) && m_win);
        check("a_rdata", a_rdata, exp_rdata[0]);
        check("b_rdata", b_rdata, exp_rdata[1]);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic wait_done(input bit port, input int budget, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            seen = port ? b_done : a_done;
        end
        check(tag, seen, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int gq[$];
        int n;
        logic [DW-1:0] saved_a;

        for (int i = 0; i < 64; i++) begin
            ram[i]     = init_val(i);
            ref_mem[i] = init_val(i);
        end
        model_reset();
        rst_n = 1'b0;
        a_req = 1'b1; a_we = 1'b1; a_addr = 6'h2A; a_wdata = 16'hBEEF;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0;    b_wdata = '0;

        // Reset with a_req held, then A writes 0x2A
        repeat (3) step();
        check("rst_ctrl_zero", {a_gnt, b_gnt, a_done, b_done, mem_e, mem_w, mem_r}, 7'd0);
        check("rst_a_rdata", a_rdata, 16'h0);
        rst_n = 1'b1;
        step();
        check("post_rst_a_gnt_2nd", a_gnt, 1'b1);
        check("a_write_mem_r_gnt", mem_r, 1'b0);
        step();
        check("post_rst_a_done_3rd", a_done, 1'b1);
        check("a_write_mem_r_done", mem_r, 1'b0);
        a_req = 1'b0;

        // B reads back 0x2A
        b_req = 1'b1; b_we = 1'b0; b_addr = 6'h2A;
        wait_done(1'b1, 8, "b_read_done_timeout");
        check("b_read_beef", b_rdata, 16'hBEEF);
        b_req = 1'b0;
        step();

        // Both ports requesting continuously
        a_req = 1'b1; a_we = 1'b0; a_addr = 6'h03;
        b_req = 1'b1; b_we = 1'b0; b_addr = 6'h04;
        repeat (12) begin
            step();
            if (a_gnt) gq.push_back(0);
            if (b_gnt) gq.push_back(1);
        end
        check("contention_grant_count", gq.size(), 4);
        foreach (gq[i]) begin
`ifdef RAM64_ARB_FIXED_PRIO_EN
            check("contention_order", gq[i], 0);
`else
            check("contention_order", gq[i], i % 2);
`endif
        end
        a_req = 1'b0; b_req = 1'b0;
        repeat (3) step();

        // Simultaneous A write / B read of 0x00, A wins
        saved_a = exp_rdata[0];
        a_req = 1'b1; a_we = 1'b1; a_addr = 6'h00; a_wdata = 16'h1234;
        b_req = 1'b1; b_we = 1'b0; b_addr = 6'h00;
        step();
        check("same_addr_a_wins", a_gnt, 1'b1);
        step();
        check("same_addr_a_done", a_done, 1'b1);
        a_req = 1'b0;
        wait_done(1'b1, 6, "same_addr_b_done_timeout");
        check("same_addr_b_rdata", b_rdata, 16'h1234);
        check("same_addr_a_rdata_kept", a_rdata, saved_a);
        b_req = 1'b0;
        step();

        // Change address and drop request during ACCESS
        a_req = 1'b1; a_we = 1'b0; a_addr = 6'h15;
        step();
        check("latch_a_gnt", a_gnt, 1'b1);
        a_addr = 6'h3F; a_req = 1'b0;
        n = 0;
        repeat (5) begin
            step();
            if (a_done) n++;
        end
        check("latch_single_done", n, 1);
        check("latch_orig_addr_data", a_rdata, init_val(6'h15));

        // Reset during ACCESS
        a_req = 1'b1; a_we = 1'b0; a_addr = 6'h01;
        b_req = 1'b1; b_we = 1'b0; b_addr = 6'h02;
        step();
        check("mid_rst_in_access", mem_e, 1'b1);
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        check("mid_rst_ctrl_zero", {a_gnt, b_gnt, a_done, b_done, mem_e, mem_w, mem_r}, 7'd0);
        check("mid_rst_addr_zero", mem_addr, 6'h0);
        check("mid_rst_din_zero", mem_din, 16'h0);
        check("mid_rst_rdata_zero", {a_rdata, b_rdata}, 32'h0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        check("post_rst_first_a_gnt", a_gnt, 1'b1);
        check("post_rst_first_b_gnt", b_gnt, 1'b0);
        a_req = 1'b0; b_req = 1'b0;
        repeat (3) step();

        // Randomized traffic; requesters hold req until their done
        for (int c = 0; c < 600; c++) begin
            if (!a_req && $urandom_range(0, 2) == 0) begin
                a_req = 1'b1; a_we = 1'($urandom_range(0, 1));
                a_addr = 6'($urandom_range(0, 7)); a_wdata = 16'($urandom);
            end
            if (!b_req && $urandom_range(0, 2) == 0) begin
                b_req = 1'b1; b_we = 1'($urandom_range(0, 1));
                b_addr = 6'($urandom_range(0, 7)); b_wdata = 16'($urandom);
            end
            step();
            if (cyc == g) begin
                if (!m_win) begin a_addr = 6'($urandom); a_wdata = 16'($urandom); end
                else        begin b_addr = 6'($urandom); b_wdata = 16'($urandom); end
            end
            if (cyc == g + 1) begin
                if (!m_win) a_req = 1'b0;
                else        b_req = 1'b0;
            end
        end
        a_req = 1'b0; b_req = 1'b0;
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
